// File: rtl/render_pkg.sv
// ---------------------------------------------------------------------------
// render_pkg
//   Shared types for the triangle dispatch path.
//   - dispatch_state_t : triangle_dispatcher FSM states
//   - vertex_t         : packed vertex {z,y,x}, x in the low bits
//   - IDX_I0..IDX_I2   : component positions of i0/i1/i2 inside an index word
// ---------------------------------------------------------------------------
package render_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_IDX_RD   = 4'd1,
      ST_IDX_CHK  = 4'd2,
      ST_VTX0     = 4'd3,
      ST_VTX1     = 4'd4,
      ST_VTX2     = 4'd5,
      ST_WAIT_RDY = 4'd6,
      ST_ISSUE    = 4'd7,
      ST_DONE     = 4'd8
   } dispatch_state_t;

   localparam int unsigned VTX_DW = 12;

   typedef struct packed {
      logic signed [VTX_DW-1:0] z;
      logic signed [VTX_DW-1:0] y;
      logic signed [VTX_DW-1:0] x;
   } vertex_t;

   // Index word layout is {i2,i1,i0}; component k sits at k*INDEX_WIDTH.
   localparam int unsigned IDX_I0 = 0;
   localparam int unsigned IDX_I1 = 1;
   localparam int unsigned IDX_I2 = 2;

endpackage

// File: rtl/triangle_dispatcher.sv
// ---------------------------------------------------------------------------
// triangle_dispatcher
//   Walks an indexed triangle list: reads the three indices of each triangle
//   from the index buffer, drops triangles with an index >= num_vertices,
//   fetches the three vertices from the vertex buffer and hands the triangle
//   to the rasterizer frontend with a one-cycle o_triangle_dv pulse.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     start           begin a draw call (accepted only when idle)
//     num_triangles   triangles in the draw call, latched on start
//     num_vertices    valid vertex count, latched on start
//     busy            high whenever not idle
//     done            one-cycle pulse at end of draw call
//     tri_issued      triangles issued in this draw call
//     tri_skipped     triangles dropped for a bad index
//     idx_addr/data   index buffer port, data = {i2,i1,i0}
//     vtx_addr/data   vertex buffer port, data = {z,y,x}
//     fe_ready        frontend ready
//     o_v0..o_v2      vertices to frontend, element [0]=x [1]=y [2]=z
//     o_triangle_dv   one-cycle issue pulse
//
//   Buffer data is consumed in the cycle after the registered address is
//   presented; all outputs are registered.
// ---------------------------------------------------------------------------
module triangle_dispatcher
   import render_pkg::*;
#(
   parameter int unsigned DATAWIDTH      = 12,
   parameter int unsigned INDEX_WIDTH    = 8,
   parameter int unsigned TRI_ADDR_WIDTH = 10
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [TRI_ADDR_WIDTH-1:0]          num_triangles,
   input  logic [INDEX_WIDTH:0]               num_vertices,
   output logic                               busy,
   output logic                               done,
   output logic [TRI_ADDR_WIDTH-1:0]          tri_issued,
   output logic [TRI_ADDR_WIDTH-1:0]          tri_skipped,
   output logic [TRI_ADDR_WIDTH-1:0]          idx_addr,
   input  logic [3*INDEX_WIDTH-1:0]           idx_data,
   output logic [INDEX_WIDTH-1:0]             vtx_addr,
   input  logic [3*DATAWIDTH-1:0]             vtx_data,
   input  logic                               fe_ready,
   output logic [2:0][DATAWIDTH-1:0]          o_v0,
   output logic [2:0][DATAWIDTH-1:0]          o_v1,
   output logic [2:0][DATAWIDTH-1:0]          o_v2,
   output logic                               o_triangle_dv
);

   dispatch_state_t             r_state;
   logic [TRI_ADDR_WIDTH-1:0]   r_ptr;
   logic [TRI_ADDR_WIDTH-1:0]   r_num_tri;
   logic [INDEX_WIDTH:0]        r_num_vtx;
   logic [INDEX_WIDTH-1:0]      r_i0;
   logic [INDEX_WIDTH-1:0]      r_i1;
   logic [INDEX_WIDTH-1:0]      r_i2;

   logic [INDEX_WIDTH-1:0]      w_i0;
   logic [INDEX_WIDTH-1:0]      w_i1;
   logic [INDEX_WIDTH-1:0]      w_i2;
   logic                        w_bad_idx;
   logic                        w_last;

   assign w_i0 = idx_data[IDX_I0*INDEX_WIDTH +: INDEX_WIDTH];
   assign w_i1 = idx_data[IDX_I1*INDEX_WIDTH +: INDEX_WIDTH];
   assign w_i2 = idx_data[IDX_I2*INDEX_WIDTH +: INDEX_WIDTH];

   // Unsigned compare at INDEX_WIDTH+1 bits so num_vertices = 2**INDEX_WIDTH
   // admits every index.
   assign w_bad_idx = ({1'b0, w_i0} >= r_num_vtx) ||
                      ({1'b0, w_i1} >= r_num_vtx) ||
                      ({1'b0, w_i2} >= r_num_vtx);

   // Only evaluated once a draw call with num_triangles > 0 is running.
   assign w_last = (r_ptr == (r_num_tri - 1'b1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_num_tri     <= '0;
         r_num_vtx     <= '0;
         r_i0          <= '0;
         r_i1          <= '0;
         r_i2          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         tri_issued    <= '0;
         tri_skipped   <= '0;
         idx_addr      <= '0;
         vtx_addr      <= '0;
         o_v0          <= '0;
         o_v1          <= '0;
         o_v2          <= '0;
         o_triangle_dv <= 1'b0;
      end else begin
         done          <= 1'b0;
         o_triangle_dv <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  tri_issued  <= '0;
                  tri_skipped <= '0;
                  r_ptr       <= '0;
                  r_num_tri   <= num_triangles;
                  r_num_vtx   <= num_vertices;
                  busy        <= 1'b1;
                  r_state     <= (num_triangles == '0) ? ST_DONE : ST_IDX_RD;
               end
            end
            ST_IDX_RD: begin
               idx_addr <= r_ptr;
               r_state  <= ST_IDX_CHK;
            end
            ST_IDX_CHK: begin
               r_i0 <= w_i0;
               r_i1 <= w_i1;
               r_i2 <= w_i2;
               if (w_bad_idx) begin
                  tri_skipped <= tri_skipped + 1'b1;
                  r_ptr       <= r_ptr + 1'b1;
                  r_state     <= w_last ? ST_DONE : ST_IDX_RD;
               end else begin
                  // Address i0 straight from the buffer word so vertex 0
                  // is readable in VTX0 without an extra cycle.
                  vtx_addr <= w_i0;
                  r_state  <= ST_VTX0;
               end
            end
            ST_VTX0: begin
               o_v0     <= vtx_data;
               vtx_addr <= r_i1;
               r_state  <= ST_VTX1;
            end
            ST_VTX1: begin
               o_v1     <= vtx_data;
               vtx_addr <= r_i2;
               r_state  <= ST_VTX2;
            end
            ST_VTX2: begin
               o_v2    <= vtx_data;
               r_state <= ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
               // Frontend drops ready while dv is high, so ready is only
               // trusted when sampled with dv low; dv then spans ISSUE.
               if (fe_ready && !o_triangle_dv) begin
                  o_triangle_dv <= 1'b1;
                  r_state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tri_issued <= tri_issued + 1'b1;
               r_ptr      <= r_ptr + 1'b1;
               r_state    <= w_last ? ST_DONE : ST_IDX_RD;
            end
            ST_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_triangle_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_triangle_dispatcher
//   Directed bench for triangle_dispatcher. Expected triangles are queued by
//   the stimulus; a negedge monitor pops and compares on every o_triangle_dv.
// ---------------------------------------------------------------------------
module tb_triangle_dispatcher;
   import render_pkg::*;

   localparam int unsigned DW = 12;
   localparam int unsigned IW = 8;
   localparam int unsigned TW = 10;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [TW-1:0]       num_triangles = '0;
   logic [IW:0]         num_vertices = '0;
   logic                busy;
   logic                done;
   logic [TW-1:0]       tri_issued;
   logic [TW-1:0]       tri_skipped;
   logic [TW-1:0]       idx_addr;
   logic [3*IW-1:0]     idx_data;
   logic [IW-1:0]       vtx_addr;
   logic [3*DW-1:0]     vtx_data;
   logic                fe_ready = 1'b0;
   logic [2:0][DW-1:0]  o_v0;
   logic [2:0][DW-1:0]  o_v1;
   logic [2:0][DW-1:0]  o_v2;
   logic                o_triangle_dv;

   logic [3*IW-1:0]     ibuf [0:15];
   vertex_t             vbuf [0:255];

   logic [107:0]        exp_q [$];
   logic [107:0]        mon_exp;
   int                  n_cmp = 0;
   int                  n_err = 0;
   int                  done_cnt = 0;

   always #5 clk = ~clk;

   assign idx_data = ibuf[idx_addr[3:0]];
   assign vtx_data = vbuf[vtx_addr];

   triangle_dispatcher #(
      .DATAWIDTH      (DW),
      .INDEX_WIDTH    (IW),
      .TRI_ADDR_WIDTH (TW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_triangles (num_triangles),
      .num_vertices  (num_vertices),
      .busy          (busy),
      .done          (done),
      .tri_issued    (tri_issued),
      .tri_skipped   (tri_skipped),
      .idx_addr      (idx_addr),
      .idx_data      (idx_data),
      .vtx_addr      (vtx_addr),
      .vtx_data      (vtx_data),
      .fe_ready      (fe_ready),
      .o_v0          (o_v0),
      .o_v1          (o_v1),
      .o_v2          (o_v2),
      .o_triangle_dv (o_triangle_dv)
   );

   function automatic logic [3*IW-1:0] mkidx(input logic [7:0] i0, input logic [7:0] i1,
                                            input logic [7:0] i2);
      return {i2, i1, i0};
   endfunction

   // Vertex k = (x=10k, y=20k, z=k); triangle = {v2,v1,v0}.
   function automatic logic [107:0] tri_exp(input int k0, input int k1, input int k2);
      logic [35:0] a, b, c;
      a = {12'(k0), 12'(20 * k0), 12'(10 * k0)};
      b = {12'(k1), 12'(20 * k1), 12'(10 * k1)};
      c = {12'(k2), 12'(20 * k2), 12'(10 * k2)};
      return {c, b, a};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [TW-1:0] nt, input logic [IW:0] nv);
      num_triangles = nt;
      num_vertices  = nv;
      start         = 1'b1;
      tick();
      start         = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s: got no done pulse expected done within 300 cycles", name);
      end
      tick();
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst && done) done_cnt++;
      if (!rst && o_triangle_dv) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tri_out: got dv with %0h expected no triangle", {o_v2, o_v1, o_v0});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({o_v2, o_v1, o_v0} !== mon_exp) begin
               n_err++;
               $display("FAIL tri_out: got %0h expected %0h", {o_v2, o_v1, o_v0}, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [107:0] held;
      for (int k = 0; k < 256; k++)
         vbuf[k] = {12'(k), 12'(20 * k), 12'(10 * k)};
      for (int k = 0; k < 16; k++)
         ibuf[k] = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_outputs", 128'({busy, done, o_triangle_dv, tri_issued, tri_skipped, idx_addr, vtx_addr}), 128'(0));
      chk("rst_vertices", 128'({o_v2, o_v1, o_v0}), 128'(0));
      rst = 1'b0;
      tick();

      // 1: two triangles, ready held high
      ibuf[0]  = mkidx(0, 1, 2);
      ibuf[1]  = mkidx(2, 1, 3);
      fe_ready = 1'b1;
      exp_q.push_back(tri_exp(0, 1, 2));
      exp_q.push_back(tri_exp(2, 1, 3));
      do_start(2, 4);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("t1_latency_dv", 128'(o_triangle_dv), 128'(1));
      wait_done("t1_done");
      chk("t1_issued", 128'(tri_issued), 128'(2));
      chk("t1_skipped", 128'(tri_skipped), 128'(0));

      // 2: empty draw call
      do_start(0, 4);
      chk("t2_busy", 128'({busy, done}), 128'(2'b10));
      tick();
      chk("t2_done", 128'({busy, done}), 128'(2'b01));
      chk("t2_issued_cleared", 128'(tri_issued), 128'(0));
      tick();
      chk("t2_done_pulse", 128'(done), 128'(0));

      // 3: frontend stalls for 20 cycles in WAIT_RDY
      ibuf[0]  = mkidx(0, 1, 2);
      fe_ready = 1'b0;
      held     = tri_exp(0, 1, 2);
      exp_q.push_back(held);
      do_start(1, 4);
      repeat (5) tick();
      for (int c = 0; c < 20; c++) begin
         chk("t3_stall_dv", 128'(o_triangle_dv), 128'(0));
         chk("t3_stall_hold", 128'({o_v2, o_v1, o_v0}), 128'(held));
         tick();
      end
      fe_ready = 1'b1;
      tick();
      chk("t3_dv_after_ready", 128'(o_triangle_dv), 128'(1));
      wait_done("t3_done");

      // 4: bad index (5 >= 4) skipped, following triangle issued
      ibuf[0] = mkidx(1, 5, 2);
      ibuf[1] = mkidx(0, 1, 2);
      exp_q.push_back(tri_exp(0, 1, 2));
      do_start(2, 4);
      wait_done("t4_done");
      chk("t4_skipped", 128'(tri_skipped), 128'(1));
      chk("t4_issued", 128'(tri_issued), 128'(1));

      // 4b: index == num_vertices on the last triangle is skipped
      ibuf[0] = mkidx(0, 4, 1);
      do_start(1, 4);
      wait_done("t4b_done");
      chk("t4b_skipped", 128'(tri_skipped), 128'(1));
      chk("t4b_issued", 128'(tri_issued), 128'(0));

      // 5: reset in VTX1, then a clean draw call
      ibuf[0] = mkidx(1, 2, 3);
      do_start(1, 4);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("t5_rst_outputs", 128'({busy, done, o_triangle_dv, tri_issued, tri_skipped, idx_addr, vtx_addr}), 128'(0));
      chk("t5_rst_vertices", 128'({o_v2, o_v1, o_v0}), 128'(0));
      rst = 1'b0;
      tick();
      exp_q.push_back(tri_exp(1, 2, 3));
      do_start(1, 4);
      wait_done("t5_done");
      chk("t5_issued", 128'(tri_issued), 128'(1));

      // 6: start pulsed while waiting for ready is ignored
      ibuf[0]  = mkidx(0, 1, 2);
      fe_ready = 1'b0;
      exp_q.push_back(tri_exp(0, 1, 2));
      d0 = done_cnt;
      do_start(1, 4);
      repeat (8) tick();
      chk("t6_busy_waiting", 128'(busy), 128'(1));
      do_start(5, 4);
      repeat (3) tick();
      chk("t6_no_dv", 128'(o_triangle_dv), 128'(0));
      fe_ready = 1'b1;
      wait_done("t6_done");
      repeat (10) tick();
      chk("t6_issued", 128'(tri_issued), 128'(1));
      chk("t6_one_done", 128'(done_cnt - d0), 128'(1));

      chk("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
